// File: rtl/seg_disp_sched_if.sv
// Bundle between the game logic and the score/countdown display scheduler.
// The game logic side drives score and the start/over pulses; the scheduler drives the display fields.
interface seg_disp_sched_if;
  logic [19:0] score;
  logic        game_start;
  logic        game_over;
  logic [19:0] data;
  logic [5:0]  point;
  logic        en;
  logic        sign;
  logic [19:0] best;
  logic        new_best;
  logic        cd_done;

  modport master (
    output score, game_start, game_over,
    input  data, point, en, sign, best, new_best, cd_done
  );

  modport slave (
    input  score, game_start, game_over,
    output data, point, en, sign, best, new_best, cd_done
  );
endinterface

// File: rtl/seg_disp_sched.sv
// 7-segment display scheduler: idle best score, start countdown, live score,
// and game-over score/best alternation with a blink when a new best is set.
module seg_disp_sched #(
  parameter int unsigned TICK_CYC = 50000,
  parameter int unsigned CD_SECS  = 3,
  parameter int unsigned DWELL_MS = 2000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_disp_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CD, PLAY, OVER} state_t;

  state_t      state;
  logic [31:0] tick_cnt;
  logic [31:0] ms_cnt;
  logic [31:0] blink_cnt;
  logic [3:0]  cd;
  logic [19:0] final_score;
  logic        view;
  logic [19:0] data_r;
  logic [5:0]  point_r;
  logic        en_r;
  logic [19:0] best_r;
  logic        new_best_r;
  logic        cd_done_r;
  logic        tick;

  function automatic logic [19:0] clamp(input logic [19:0] v);
    return (v > 20'd9999) ? 20'd9999 : v;
  endfunction

  assign tick = (tick_cnt == TICK_CYC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      ms_cnt      <= '0;
      blink_cnt   <= '0;
      cd          <= '0;
      final_score <= '0;
      view        <= 1'b0;
      data_r      <= '0;
      point_r     <= '0;
      en_r        <= 1'b1;
      best_r      <= '0;
      new_best_r  <= 1'b0;
      cd_done_r   <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 32'd1;
      cd_done_r <= 1'b0;
      case (state)
        IDLE: begin
          data_r  <= clamp(best_r);
          point_r <= '0;
          en_r    <= 1'b1;
          if (bus.game_start) begin
            state    <= CD;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            cd       <= 4'(CD_SECS);
            data_r   <= 20'(CD_SECS);
          end
        end
        CD: begin
          // ms_cnt counts ticks within the current second; game_start is ignored here
          if (tick) begin
            if (ms_cnt == 32'd999) begin
              ms_cnt <= '0;
              if (cd == 4'd1) begin
                state     <= PLAY;
                tick_cnt  <= '0;
                cd_done_r <= 1'b1;
                data_r    <= clamp(bus.score);
              end else begin
                cd     <= cd - 4'd1;
                data_r <= 20'(cd - 4'd1);
              end
            end else begin
              ms_cnt <= ms_cnt + 32'd1;
            end
          end
        end
        PLAY: begin
          data_r  <= clamp(bus.score);
          point_r <= '0;
          en_r    <= 1'b1;
          if (bus.game_over) begin
            state       <= OVER;
            tick_cnt    <= '0;
            ms_cnt      <= '0;
            blink_cnt   <= '0;
            view        <= 1'b0;
            final_score <= bus.score;
            if (bus.score > best_r) begin
              best_r     <= bus.score;
              new_best_r <= 1'b1;
            end else begin
              new_best_r <= 1'b0;
            end
          end
        end
        OVER: begin
          if (bus.game_start) begin
            state      <= CD;
            tick_cnt   <= '0;
            ms_cnt     <= '0;
            cd         <= 4'(CD_SECS);
            data_r     <= 20'(CD_SECS);
            point_r    <= '0;
            en_r       <= 1'b1;
            new_best_r <= 1'b0;
          end else if (tick) begin
            // dwell and blink run on independent ms counters so their periods need not nest
            if (ms_cnt == DWELL_MS - 1) begin
              ms_cnt  <= '0;
              view    <= ~view;
              data_r  <= view ? clamp(final_score) : clamp(best_r);
              point_r <= view ? 6'b000000 : 6'b001000;
            end else begin
              ms_cnt <= ms_cnt + 32'd1;
            end
            if (blink_cnt == BLINK_MS - 1) begin
              blink_cnt <= '0;
              if (new_best_r) en_r <= ~en_r;
            end else begin
              blink_cnt <= blink_cnt + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data     = data_r;
  assign bus.point    = point_r;
  assign bus.en       = en_r;
  assign bus.sign     = 1'b0;
  assign bus.best     = best_r;
  assign bus.new_best = new_best_r;
  assign bus.cd_done  = cd_done_r;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with a 10-cycle ms tick, 3 s countdown,
// 20 ms dwell and 5 ms blink; outputs are sampled on the falling clock edge.
module tb_seg_disp_sched;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cd_pulses;

  seg_disp_sched_if bus();

  seg_disp_sched #(
    .TICK_CYC(10),
    .CD_SECS (3),
    .DWELL_MS(20),
    .BLINK_MS(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // counts cd_done pulses; a pulse registered at edge E is counted at edge E+1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cd_pulses <= cd_pulses;
    else if (bus.cd_done === 1'b1) cd_pulses <= cd_pulses + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cd_pulses = 0;
    rst_n = 1'b0;
    bus.score = '0;
    bus.game_start = 1'b0;
    bus.game_over = 1'b0;
    adv(3);
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_en", 32'(bus.en), 1);
    chk("rst_best", 32'(bus.best), 0);
    chk("rst_new_best", 32'(bus.new_best), 0);
    chk("rst_point", 32'(bus.point), 0);
    chk("rst_cd_done", 32'(bus.cd_done), 0);
    chk("rst_sign", 32'(bus.sign), 0);
    rst_n = 1'b1;
    adv(2);

    // stray game_over in IDLE does nothing
    bus.game_over = 1'b1; adv(1); bus.game_over = 1'b0; adv(3);
    chk("idle_data", 32'(bus.data), 0);
    chk("idle_en", 32'(bus.en), 1);
    chk("idle_new_best", 32'(bus.new_best), 0);

    // game 1: countdown
    bus.score = 20'd42;
    bus.game_start = 1'b1; adv(1); bus.game_start = 1'b0;   // k=0
    chk("cd3_entry", 32'(bus.data), 3);
    adv(4999);
    bus.game_start = 1'b1; adv(1); bus.game_start = 1'b0;   // k=5000
    chk("cd_start_ignored", 32'(bus.data), 3);
    adv(4999);                                              // k=9999
    chk("cd3_hold", 32'(bus.data), 3);
    adv(1);                                                 // k=10000
    chk("cd2_entry", 32'(bus.data), 2);
    adv(9999);                                              // k=19999
    chk("cd2_hold", 32'(bus.data), 2);
    adv(1);                                                 // k=20000
    chk("cd1_entry", 32'(bus.data), 1);
    adv(9998);                                              // k=29998
    bus.game_start = 1'b1; adv(1);                          // k=29999
    chk("cd1_hold", 32'(bus.data), 1);
    chk("cd_done_early", 32'(bus.cd_done), 0);
    adv(1); bus.game_start = 1'b0;                          // k=30000
    chk("cd_done_pulse", 32'(bus.cd_done), 1);
    chk("play_entry_data", 32'(bus.data), 42);
    bus.score = 20'd7; adv(1);
    chk("cd_done_single", 32'(bus.cd_done), 0);
    chk("play_track7", 32'(bus.data), 7);
    chk("cd_pulses_g1", 32'(cd_pulses), 1);
    bus.score = 20'd9999; adv(1);
    chk("play_9999", 32'(bus.data), 9999);
    bus.score = 20'd10000; adv(1);
    chk("play_clamp10000", 32'(bus.data), 9999);
    bus.score = 20'd12345; adv(1);
    chk("play_clamp12345", 32'(bus.data), 9999);
    bus.game_start = 1'b1; adv(1); bus.game_start = 1'b0;
    chk("play_start_ignored", 32'(bus.data), 9999);

    // game 1 over with new best
    bus.game_over = 1'b1; adv(1); bus.game_over = 1'b0;     // j=0
    bus.score = 20'd5;
    chk("over1_best", 32'(bus.best), 12345);
    chk("over1_new_best", 32'(bus.new_best), 1);
    chk("over1_en_entry", 32'(bus.en), 1);
    chk("over1_data", 32'(bus.data), 9999);
    chk("over1_point", 32'(bus.point), 0);
    adv(49);  chk("blink_j49", 32'(bus.en), 1);
    adv(1);   chk("blink_j50", 32'(bus.en), 0);
    adv(49);  chk("blink_j99", 32'(bus.en), 0);
    adv(1);   chk("blink_j100", 32'(bus.en), 1);
    adv(99);  chk("view1_j199_point", 32'(bus.point), 0);
    adv(1);   chk("view1_j200_point", 32'(bus.point), 8);
    chk("view1_j200_data", 32'(bus.data), 9999);

    // game 2: final score below best
    bus.score = 20'd10;
    bus.game_start = 1'b1; adv(1); bus.game_start = 1'b0;   // k=0
    chk("g2_cd_entry", 32'(bus.data), 3);
    chk("g2_new_best_clr", 32'(bus.new_best), 0);
    chk("g2_en", 32'(bus.en), 1);
    chk("g2_point", 32'(bus.point), 0);
    adv(30000);
    chk("g2_cd_done", 32'(bus.cd_done), 1);
    chk("g2_play_data", 32'(bus.data), 10);
    chk("g2_pulses_before", 32'(cd_pulses), 1);

    // simultaneous start and over: over wins
    bus.game_start = 1'b1; bus.game_over = 1'b1; adv(1);
    bus.game_start = 1'b0; bus.game_over = 1'b0;            // j=0
    chk("g2_over_data", 32'(bus.data), 10);
    chk("g2_over_new_best", 32'(bus.new_best), 0);
    chk("g2_over_best", 32'(bus.best), 12345);
    chk("g2_cd_pulses", 32'(cd_pulses), 2);
    adv(10);
    chk("g2_no_restart", 32'(bus.data), 10);
    adv(40);  chk("g2_en_j50", 32'(bus.en), 1);
    adv(50);  chk("g2_en_j100", 32'(bus.en), 1);
    adv(99);  chk("g2_view_j199", 32'(bus.data), 10);
    adv(1);   chk("g2_view_j200", 32'(bus.data), 9999);
    chk("g2_point_j200", 32'(bus.point), 8);
    adv(199); chk("g2_view_j399", 32'(bus.data), 9999);
    adv(1);   chk("g2_view_j400", 32'(bus.data), 10);
    chk("g2_point_j400", 32'(bus.point), 0);

    // reset during countdown with cd=2
    bus.game_start = 1'b1; adv(1); bus.game_start = 1'b0;
    chk("g3_cd_entry", 32'(bus.data), 3);
    adv(10000);
    chk("g3_cd2", 32'(bus.data), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(bus.data), 0);
    chk("mid_rst_best", 32'(bus.best), 0);
    chk("mid_rst_en", 32'(bus.en), 1);
    adv(2);
    rst_n = 1'b1;
    adv(2000);
    chk("post_rst_data", 32'(bus.data), 0);
    chk("post_rst_best", 32'(bus.best), 0);
    chk("post_rst_pulses", 32'(cd_pulses), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seg_disp_sched.md
SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

Interface
REQ-001 Parameter TICK_CYC, default 50000, meaning clk cycles per 1 ms tick (50 MHz clk).
REQ-002 Parameter CD_SECS, default 3, meaning countdown start value in seconds (1..9).
REQ-003 Parameter DWELL_MS, default 2000, meaning ms per view in the game-over score/best alternation.
REQ-004 Parameter BLINK_MS, default 250, meaning ms per half-period of the new-best blink.
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 score  input  20  live game score, binary.
REQ-008 game_start  input  1  one-cycle start pulse.
REQ-009 game_over  input  1  one-cycle end-of-game pulse.
REQ-010 data  output  20  value to the 7-seg display driver.
REQ-011 point  output  6  decimal-point mask to the display driver.
REQ-012 en  output  1  display enable.
REQ-013 sign  output  1  minus-sign request; constant 0.
REQ-014 best  output  20  best score since reset.
REQ-015 new_best  output  1  level; last game set a new best.
REQ-016 cd_done  output  1  one-cycle pulse when countdown expires.

Function
REQ-017 The block SHALL derive a 1 ms tick from a counter of TICK_CYC cycles; the counter SHALL restart on every state entry.
REQ-018 The state machine SHALL have states IDLE, CD, PLAY and OVER.
REQ-019 IDLE: data=best, point=0, en=1; game_start -> CD.
REQ-020 CD: cd counter loaded with CD_SECS on entry; data=cd, point=0, en=1; decrement after every 1000 ticks.
REQ-021 CD: when the second with cd=1 elapses, go to PLAY and pulse cd_done for exactly one cycle in the same cycle as entry into PLAY.
REQ-022 PLAY: data SHALL follow score with a one-cycle registered latency; point=0, en=1.
REQ-023 PLAY: game_over -> OVER.
REQ-024 Transition PLAY->OVER: if score > best then best<=score and new_best<=1, else new_best<=0.
REQ-025 OVER: view alternates every DWELL_MS; it starts with the score view (data=final score, point=0), then the best view (data=best, point=6'b001000).
REQ-026 OVER with new_best=1: en SHALL toggle every BLINK_MS, starting at 1 on entry; with new_best=0, en=1.
REQ-027 OVER: game_start -> CD; new_best SHALL clear and en SHALL return to 1 on that transition.
REQ-028 Every value driven on data SHALL be clamped to min(value, 9999) because the display is 4 digits; best SHALL store the unclamped score.
REQ-029 game_start SHALL be ignored in CD and PLAY; game_over SHALL be ignored outside PLAY.
REQ-030 If game_start and game_over are asserted in the same cycle in PLAY, game_over SHALL win.
REQ-031 A game_start that arrives in the same cycle as the CD->PLAY transition SHALL be ignored.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On rst_n low, asynchronously: state=IDLE, best=0, new_best=0, data=0, point=0, en=1, sign=0, cd_done=0, all counters=0.
REQ-034 Reset asserted mid-game SHALL abandon the game, clear best, and emit no cd_done.

Verification (TICK_CYC=10, CD_SECS=3, DWELL_MS=20, BLINK_MS=5)
REQ-035 Reset release -> data=0, en=1, state IDLE; game_over pulse -> no change.
REQ-036 game_start -> data 3, then 2, then 1, each held 10000 cycles; cd_done pulses once at 30000 cycles; data then tracks score=42 one cycle later.
REQ-037 score=12345 in PLAY -> data=9999; game_over -> best=12345, new_best=1, en toggles every 50 cycles, view switches to data=9999 with point=6'b001000 after 200 cycles.
REQ-038 Second game with final score 10 < best -> new_best=0, en steady 1, views alternate data=10 and data=9999.
REQ-039 game_start and game_over in the same PLAY cycle -> OVER entered, no restart of the countdown.
REQ-040 rst_n pulsed during CD with cd=2 -> IDLE, data=0, best=0, no cd_done pulse.
